// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
// Shared definitions for the general-register file and its busy scoreboard:
// default sizes, the address-width helper, the zero-register index,
// the reset level and the pending-counter update kinds.
package reg_file_sb_pkg;

  localparam int   XLEN_DEF     = 32;
  localparam int   NREG_DEF     = 32;
  localparam int   ZERO_REG     = 0;
  localparam logic RESET_ACTIVE = 1'b1;

  // How the pending-register counter moves on a clock edge.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cntOpT;

  // Register-address width; a two-entry file still needs one address bit.
  function automatic int addrWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
// Groups the decode-side read/issue signals and the writeback signals of
// the register file into one bundle.
//   rsIn/DataOut        : NRD packed read ports (address in, data out)
//   rdIn/DataIn/WriteIn : writeback port
//   issueIn/issueRdIn   : marks a destination register busy
//   busyOut/stallOut    : per-port hazard flags and their OR
//   pendOut             : number of busy registers
//   portOut             : low bits of the LED mirror register
// master = pipeline side driving the file, slave = the register file.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int PORT_W = 16
);
  localparam int AW = addrWidth(NREG);

  logic [NRD*AW-1:0]   rsIn;
  logic [NRD*XLEN-1:0] DataOut;
  logic [AW-1:0]       rdIn;
  logic [XLEN-1:0]     DataIn;
  logic                WriteIn;
  logic                issueIn;
  logic [AW-1:0]       issueRdIn;
  logic [NRD-1:0]      busyOut;
  logic                stallOut;
  logic [AW:0]         pendOut;
  logic [PORT_W-1:0]   portOut;

  modport master (
    output rsIn, rdIn, DataIn, WriteIn, issueIn, issueRdIn,
    input  DataOut, busyOut, stallOut, pendOut, portOut
  );

  modport slave (
    input  rsIn, rdIn, DataIn, WriteIn, issueIn, issueRdIn,
    output DataOut, busyOut, stallOut, pendOut, portOut
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard
// Per-register busy bits for load-use / writeback hazard detection.
// Ports:
//   clkIn, resetIn      : clock, synchronous active-high reset
//   rsIn                : NRD packed source addresses being looked up
//   rdIn, WriteIn       : writeback, clears the destination's busy bit
//   issueIn, issueRdIn  : issue, sets the destination's busy bit
//   busyOut, stallOut   : per-port pending flag and its OR
//   pendOut             : registered count of busy registers
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = addrWidth(NREG_DEF)
)(
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic [NRD*AW-1:0] rsIn,
  input  logic [AW-1:0]     rdIn,
  input  logic              WriteIn,
  input  logic              issueIn,
  input  logic [AW-1:0]     issueRdIn,
  output logic [NRD-1:0]    busyOut,
  output logic              stallOut,
  output logic [AW:0]       pendOut
);

  localparam int             CW        = AW + 1;
  localparam logic [AW-1:0]  ZERO_ADDR = AW'(ZERO_REG);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busyNext;
  logic [AW:0]     pendCount;
  logic            setValid;
  logic            clearValid;
  logic            incPend;
  logic            decPend;
  cntOpT           cntOp;

  assign setValid   = issueIn && (issueRdIn != ZERO_ADDR);
  assign clearValid = WriteIn && (rdIn != ZERO_ADDR);

  // Issue is applied after the clear so a same-register write+issue leaves
  // the register busy for the newer producer.
  always_comb begin
    busyNext = busy;
    if (clearValid) busyNext[rdIn] = 1'b0;
    if (setValid) busyNext[issueRdIn] = 1'b1;
  end

  // The count only moves on real 0->1 / 1->0 transitions, so it always
  // equals the popcount of the busy vector.
  assign incPend = setValid && !busy[issueRdIn];
  assign decPend = clearValid && busy[rdIn] && !(setValid && (issueRdIn == rdIn));

  always_comb begin
    cntOp = CNT_HOLD;
    case ({incPend, decPend})
      2'b10:   cntOp = CNT_INC;
      2'b01:   cntOp = CNT_DEC;
      default: cntOp = CNT_HOLD;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (resetIn == RESET_ACTIVE) begin
      busy      <= '0;
      pendCount <= '0;
    end else begin
      busy <= busyNext;
      case (cntOp)
        CNT_INC: pendCount <= pendCount + CW'(1);
        CNT_DEC: pendCount <= pendCount - CW'(1);
        default: pendCount <= pendCount;
      endcase
    end
  end

  // A source being written back this cycle is no longer a hazard.
  for (genvar p = 0; p < NRD; p++) begin : gBusy
    logic [AW-1:0] rs;
    assign rs         = rsIn[p*AW +: AW];
    assign busyOut[p] = (rs != ZERO_ADDR) && busy[rs] && !(WriteIn && (rdIn == rs));
  end

  assign stallOut = |busyOut;
  assign pendOut  = pendCount;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// General-register file for the pipelined core with a hardwired-zero
// register 0, write-to-read bypass, a busy scoreboard and an LED mirror.
// Ports:
//   clkIn   : clock, all state on the rising edge
//   resetIn : synchronous active-high reset
//   bus     : reg_file_sb_if.slave (read ports, writeback, issue, hazard
//             flags, pending count, LED mirror)
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int PORT_REG = 31,
  parameter int PORT_W   = 16
)(
  input  logic         clkIn,
  input  logic         resetIn,
  reg_file_sb_if.slave bus
);

  localparam int            AW        = addrWidth(NREG);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0]     regs [NREG];
  logic [NRD*XLEN-1:0] readData;

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clkIn) begin
    if (resetIn == RESET_ACTIVE) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.WriteIn && (bus.rdIn != ZERO_ADDR)) begin
      regs[bus.rdIn] <= bus.DataIn;
    end
  end

  // Same-cycle writeback data is forwarded ahead of storage.
  for (genvar p = 0; p < NRD; p++) begin : gRead
    logic [AW-1:0] rs;
    assign rs = bus.rsIn[p*AW +: AW];
    assign readData[p*XLEN +: XLEN] =
      (rs == ZERO_ADDR)                       ? '0 :
      (bus.WriteIn && (bus.rdIn == rs))       ? bus.DataIn :
                                                regs[rs];
  end

  assign bus.DataOut = readData;

  // The LED mirror shows storage only, never the bypassed value.
  assign bus.portOut = regs[PORT_REG][PORT_W-1:0];

  reg_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) scoreboard (
    .clkIn     (clkIn),
    .resetIn   (resetIn),
    .rsIn      (bus.rsIn),
    .rdIn      (bus.rdIn),
    .WriteIn   (bus.WriteIn),
    .issueIn   (bus.issueIn),
    .issueRdIn (bus.issueRdIn),
    .busyOut   (bus.busyOut),
    .stallOut  (bus.stallOut),
    .pendOut   (bus.pendOut)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Self-checking bench for reg_file_sb. Expected values are queued when
// stimulus is driven and popped when the outputs are sampled.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int NRD      = 2;
  localparam int PORT_REG = 31;
  localparam int PORT_W   = 16;
  localparam int AW       = addrWidth(NREG);

  typedef struct {
    string       name;
    logic [63:0] value;
  } expT;

  logic clkIn   = 1'b0;
  logic resetIn = 1'b1;

  expT expQ[$];
  expT e;
  int  passCount  = 0;
  int  checkCount = 0;

  reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .PORT_W(PORT_W)) bus();

  reg_file_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .PORT_REG(PORT_REG), .PORT_W(PORT_W)
  ) dut (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .bus     (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  always #5 clkIn = ~clkIn;

  // Drives one cycle of inputs on the falling edge.
  task automatic applyStimulus(input logic we, input int rd, input logic [31:0] data,
                               input logic iss, input int issRd,
                               input int rs0, input int rs1);
    @(negedge clkIn);
    bus.WriteIn   = we;
    bus.rdIn      = AW'(rd);
    bus.DataIn    = data;
    bus.issueIn   = iss;
    bus.issueRdIn = AW'(issRd);
    bus.rsIn      = {AW'(rs1), AW'(rs0)};
  endtask

  task automatic test_reset();
    resetIn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    resetIn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expQ.push_back('{"resetPend", 64'(0)});
    expQ.push_back('{"resetStall", 64'(0)});
    expQ.push_back('{"resetPort", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.stallOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.stallOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.portOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.portOut, e.value); else passCount++;
    for (int a = 0; a < NREG; a++) begin
      bus.rsIn = {AW'(NREG - 1 - a), AW'(a)};
      expQ.push_back('{$sformatf("resetData%0d", a), 64'(0)});
      expQ.push_back('{$sformatf("resetBusy%0d", a), 64'(0)});
      #1;
      e = expQ.pop_front(); checkCount++;
      if (64'(bus.DataOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut, e.value); else passCount++;
      e = expQ.pop_front(); checkCount++;
      if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    end
  endtask

  task automatic test_bypass();
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    expQ.push_back('{"bypassPort0", 64'hDEADBEEF});
    expQ.push_back('{"bypassPort1", 64'hDEADBEEF});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[63:32]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[63:32], e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 5, 0);
    expQ.push_back('{"storedRead5", 64'hDEADBEEF});
    expQ.push_back('{"port1Zero", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[63:32]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[63:32], e.value); else passCount++;
  endtask

  task automatic test_zero_reg();
    applyStimulus(1, 0, 32'h1234, 1, 0, 0, 0);
    expQ.push_back('{"zeroWriteBypass", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expQ.push_back('{"zeroRead", 64'(0)});
    expQ.push_back('{"zeroBusy", 64'(0)});
    expQ.push_back('{"zeroPend", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
  endtask

  task automatic test_busy();
    applyStimulus(0, 0, 0, 1, 7, 5, 7);
    expQ.push_back('{"issueCycleBusy", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 5, 7);
    expQ.push_back('{"busyPort1", 64'b10});
    expQ.push_back('{"busyStall", 64'(1)});
    expQ.push_back('{"busyPend", 64'(1)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.stallOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.stallOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    applyStimulus(1, 7, 32'h77, 0, 0, 5, 7);
    expQ.push_back('{"wbClearBusy", 64'(0)});
    expQ.push_back('{"wbClearStall", 64'(0)});
    expQ.push_back('{"wbBypass", 64'h77});
    expQ.push_back('{"wbPendHeld", 64'(1)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.stallOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.stallOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[63:32]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[63:32], e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 5, 7);
    expQ.push_back('{"pendAfterWb", 64'(0)});
    expQ.push_back('{"stored7", 64'h77});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[63:32]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[63:32], e.value); else passCount++;
  endtask

  task automatic test_same_cycle();
    applyStimulus(1, 9, 32'hAAAA5555, 1, 9, 9, 0);
    expQ.push_back('{"sameCycleBypass", 64'hAAAA5555});
    expQ.push_back('{"sameCycleBusyNow", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 9, 0);
    expQ.push_back('{"sameCycleStored", 64'hAAAA5555});
    expQ.push_back('{"sameCycleBusy", 64'b01});
    expQ.push_back('{"sameCyclePend", 64'(1)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    // Re-issue of an already busy register must not bump the count.
    applyStimulus(0, 0, 0, 1, 9, 9, 0);
    applyStimulus(0, 0, 0, 0, 0, 9, 0);
    expQ.push_back('{"reissuePend", 64'(1)});
    expQ.push_back('{"reissueBusy", 64'b01});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    // Clear 9 while issuing 10: net count change is zero.
    applyStimulus(1, 9, 32'h99, 1, 10, 9, 10);
    expQ.push_back('{"mixedNow", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 9, 10);
    expQ.push_back('{"mixedBusy", 64'b10});
    expQ.push_back('{"mixedPend", 64'(1)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    applyStimulus(1, 10, 32'h5, 0, 0, 9, 10);
    applyStimulus(0, 0, 0, 0, 0, 9, 10);
    expQ.push_back('{"drainPend", 64'(0)});
    expQ.push_back('{"drainBusy", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
  endtask

  task automatic test_port_reset();
    applyStimulus(1, 31, 32'h0001ABCD, 0, 0, 31, 0);
    expQ.push_back('{"portNoBypass", 64'(0)});
    expQ.push_back('{"portRegBypass", 64'h0001ABCD});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.portOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.portOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut[31:0]) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut[31:0], e.value); else passCount++;
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    expQ.push_back('{"portUpdated", 64'hABCD});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.portOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.portOut, e.value); else passCount++;
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 1, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 2);
    expQ.push_back('{"pendThree", 64'(3)});
    expQ.push_back('{"busyThree", 64'b11});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    // Reset must win over the write and issue presented with it.
    applyStimulus(1, 31, 32'hFFFF, 1, 4, 31, 4);
    resetIn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 31, 1);
    resetIn = 1'b0;
    expQ.push_back('{"midResetPend", 64'(0)});
    expQ.push_back('{"midResetPort", 64'(0)});
    expQ.push_back('{"midResetData", 64'(0)});
    expQ.push_back('{"midResetBusy", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.pendOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.pendOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.portOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.portOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.DataOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.DataOut, e.value); else passCount++;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
    applyStimulus(0, 0, 0, 0, 0, 4, 0);
    expQ.push_back('{"resetDroppedIssue", 64'(0)});
    #1;
    e = expQ.pop_front(); checkCount++;
    if (64'(bus.busyOut) !== e.value) $display("[TB] FAIL %s: got %0h expected %0h", e.name, bus.busyOut, e.value); else passCount++;
  endtask

  initial begin
    bus.WriteIn   = 1'b0;
    bus.rdIn      = '0;
    bus.DataIn    = '0;
    bus.issueIn   = 1'b0;
    bus.issueRdIn = '0;
    bus.rsIn      = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_busy();
    test_same_cycle();
    test_port_reset();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
